// File: rtl/mem_access_unit_if.sv
// Beat-level memory bus of the load/store unit: one request per beat, grant,
// then in-order read data return for granted read beats.
interface mem_access_unit_if #(
    parameter int BUS_BYTES = 1
);
    logic                   mem_req_o;
    logic                   mem_wr_o;
    logic [31:0]            mem_addr_o;
    logic [8*BUS_BYTES-1:0] mem_wdata_o;
    logic [BUS_BYTES-1:0]   mem_wmask_o;
    logic                   mem_gnt_i;
    logic                   mem_rvalid_i;
    logic [8*BUS_BYTES-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs RV32I byte/half/word accesses as a sequence
// of BUS_BYTES-wide beats and stalls the pipeline until the access completes.
module mem_access_unit #(
    parameter int BUS_BYTES   = 1,
    parameter bit CHECK_ALIGN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_enable_i,
    input  logic              store_enable_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [31:0]       rd_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_write_enable_i,
    output logic              stall_req_o,
    mem_access_unit_if.master mem,
    output logic [31:0]       rd_data_o,
    output logic [4:0]        rd_addr_o,
    output logic              rd_write_enable_o,
    output logic              err_o
);
    localparam int LANE_W = 8 * BUS_BYTES;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

    state_e              state_q;
    logic [1:0]          beat_q;
    logic [2:0]          nbytes_q;
    logic                is_load_q;
    logic                sext_q;
    logic                after_rst_q;
    logic [31:0]         asm_q;
    logic [31:0]         wsrc_q;
    logic                req_q;
    logic                wr_q;
    logic [31:0]         addr_q;
    logic [LANE_W-1:0]   wdata_q;
    logic [BUS_BYTES-1:0] wmask_q;

    function automatic logic [BUS_BYTES-1:0] lane_mask(input logic [1:0] k, input logic [2:0] n);
        logic [BUS_BYTES-1:0] m;
        for (int j = 0; j < BUS_BYTES; j++) begin
            m[j] = (int'(k) * BUS_BYTES + j) < int'(n);
        end
        return m;
    endfunction

    function automatic logic [LANE_W-1:0] lane_data(input logic [31:0] src, input logic [BUS_BYTES-1:0] m);
        logic [LANE_W-1:0] d;
        d = '0;
        for (int j = 0; j < BUS_BYTES; j++) begin
            if (m[j]) d[8*j +: 8] = src[8*j +: 8];
        end
        return d;
    endfunction

    // Operation decode; the cycle right after reset never starts an access.
    logic       is_mem, legal, misaligned, idle_ok, start, op_err;
    logic [2:0] op_nbytes;

    always_comb begin
        is_mem = load_enable_i | store_enable_i;
        case (funct3_i[1:0])
            2'b00:   op_nbytes = 3'd1;
            2'b01:   op_nbytes = 3'd2;
            default: op_nbytes = 3'd4;
        endcase
        if (load_enable_i) legal = (funct3_i != 3'b011) && (funct3_i[2:1] != 2'b11);
        else               legal = !funct3_i[2] && (funct3_i[1:0] != 2'b11);
        misaligned = CHECK_ALIGN &&
                     (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
        idle_ok = (state_q == IDLE) && !after_rst_q && !rst;
        start   = idle_ok && is_mem && legal && !misaligned;
        op_err  = idle_ok && is_mem && !(legal && !misaligned);
    end

    logic                 last_beat;
    logic [1:0]           beat_next;
    logic [31:0]          wsrc_next;
    logic [BUS_BYTES-1:0] mask_next;
    logic [31:0]          asm_merged;
    logic [1:0]           byte_idx;

    always_comb begin
        last_beat  = ((int'(beat_q) + 1) * BUS_BYTES) >= int'(nbytes_q);
        beat_next  = beat_q + 2'd1;
        wsrc_next  = wsrc_q >> LANE_W;
        mask_next  = lane_mask(beat_next, nbytes_q);
        asm_merged = asm_q;
        byte_idx   = 2'd0;
        for (int j = 0; j < BUS_BYTES; j++) begin
            byte_idx = 2'(int'(beat_q) * BUS_BYTES + j);
            if (wmask_q[j]) asm_merged[{byte_idx, 3'b000} +: 8] = mem.mem_rdata_i[8*j +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            nbytes_q    <= 3'd0;
            is_load_q   <= 1'b0;
            sext_q      <= 1'b0;
            after_rst_q <= 1'b1;
            asm_q       <= '0;
            wsrc_q      <= '0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            after_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        beat_q    <= 2'd0;
                        nbytes_q  <= op_nbytes;
                        is_load_q <= load_enable_i;
                        sext_q    <= ~funct3_i[2];
                        asm_q     <= '0;
                        wsrc_q    <= store_data_i;
                        req_q     <= 1'b1;
                        wr_q      <= ~load_enable_i;
                        addr_q    <= addr_i;
                        wmask_q   <= lane_mask(2'd0, op_nbytes);
                        wdata_q   <= load_enable_i ? '0 : lane_data(store_data_i, lane_mask(2'd0, op_nbytes));
                    end
                end
                REQ: begin
                    if (mem.mem_gnt_i) begin
                        if (is_load_q) begin
                            state_q <= WAIT_R;
                            req_q   <= 1'b0;
                        end else if (last_beat) begin
                            state_q <= DONE;
                            req_q   <= 1'b0;
                            wmask_q <= '0;
                            wdata_q <= '0;
                        end else begin
                            beat_q  <= beat_next;
                            addr_q  <= addr_q + 32'(BUS_BYTES);
                            wsrc_q  <= wsrc_next;
                            wmask_q <= mask_next;
                            wdata_q <= lane_data(wsrc_next, mask_next);
                        end
                    end
                end
                WAIT_R: begin
                    // Read data is only taken here, never in the grant cycle.
                    if (mem.mem_rvalid_i) begin
                        asm_q <= asm_merged;
                        if (last_beat) begin
                            state_q <= DONE;
                            wmask_q <= '0;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            beat_q  <= beat_next;
                            addr_q  <= addr_q + 32'(BUS_BYTES);
                            wmask_q <= mask_next;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [31:0] load_result;

    always_comb begin
        case (nbytes_q)
            3'd1:    load_result = sext_q ? {{24{asm_q[7]}}, asm_q[7:0]} : {24'd0, asm_q[7:0]};
            3'd2:    load_result = sext_q ? {{16{asm_q[15]}}, asm_q[15:0]} : {16'd0, asm_q[15:0]};
            default: load_result = asm_q;
        endcase
    end

    assign mem.mem_req_o   = req_q & ~rst;
    assign mem.mem_wr_o    = wr_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_wmask_o = rst ? '0 : wmask_q;

    assign stall_req_o       = !rst && (start || (state_q == REQ) || (state_q == WAIT_R));
    assign err_o             = op_err;
    assign rd_data_o         = ((state_q == DONE) && is_load_q) ? load_result : rd_data_i;
    assign rd_addr_o         = rd_addr_i;
    assign rd_write_enable_o = rd_write_enable_i & ~op_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: three instances cover 1-, 2- and 4-lane
// buses (the 4-lane one with alignment checking); only the selected one sees ops.
module tb_mem_access_unit;
    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic        le, se, rdwe;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rdi;
    logic [4:0]  rda;

    logic        stall1, stall2, stall4, err1, err2, err4, rdwe1, rdwe2, rdwe4;
    logic [31:0] rdd1, rdd2, rdd4;
    logic [4:0]  rda1, rda2, rda4;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if #(.BUS_BYTES(1)) bus1();
    mem_access_unit_if #(.BUS_BYTES(2)) bus2();
    mem_access_unit_if #(.BUS_BYTES(4)) bus4();

    mem_access_unit #(.BUS_BYTES(1), .CHECK_ALIGN(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .load_enable_i(le && sel == 2'd0), .store_enable_i(se && sel == 2'd0),
        .funct3_i(f3), .addr_i(addr), .store_data_i(sd), .rd_data_i(rdi),
        .rd_addr_i(rda), .rd_write_enable_i(rdwe), .stall_req_o(stall1), .mem(bus1.master),
        .rd_data_o(rdd1), .rd_addr_o(rda1), .rd_write_enable_o(rdwe1), .err_o(err1)
    );

    mem_access_unit #(.BUS_BYTES(2), .CHECK_ALIGN(1'b0)) u2 (
        .clk(clk), .rst(rst),
        .load_enable_i(le && sel == 2'd1), .store_enable_i(se && sel == 2'd1),
        .funct3_i(f3), .addr_i(addr), .store_data_i(sd), .rd_data_i(rdi),
        .rd_addr_i(rda), .rd_write_enable_i(rdwe), .stall_req_o(stall2), .mem(bus2.master),
        .rd_data_o(rdd2), .rd_addr_o(rda2), .rd_write_enable_o(rdwe2), .err_o(err2)
    );

    mem_access_unit #(.BUS_BYTES(4), .CHECK_ALIGN(1'b1)) u4 (
        .clk(clk), .rst(rst),
        .load_enable_i(le && sel == 2'd2), .store_enable_i(se && sel == 2'd2),
        .funct3_i(f3), .addr_i(addr), .store_data_i(sd), .rd_data_i(rdi),
        .rd_addr_i(rda), .rd_write_enable_i(rdwe), .stall_req_o(stall4), .mem(bus4.master),
        .rd_data_o(rdd4), .rd_addr_o(rda4), .rd_write_enable_o(rdwe4), .err_o(err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sw_bytes [4];
        sw_bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

        clk = 1'b0; rst = 1'b1; sel = 2'd0; le = 1'b0; se = 1'b0; f3 = 3'd0;
        addr = '0; sd = '0; rdi = 32'h1357_9BDF; rda = 5'd7; rdwe = 1'b1;
        bus1.mem_gnt_i = 1'b0; bus1.mem_rvalid_i = 1'b0; bus1.mem_rdata_i = '0;
        bus2.mem_gnt_i = 1'b0; bus2.mem_rvalid_i = 1'b0; bus2.mem_rdata_i = '0;
        bus4.mem_gnt_i = 1'b0; bus4.mem_rvalid_i = 1'b0; bus4.mem_rdata_i = '0;

        // Reset and the cycle after it
        cyc(); cyc();
        rst = 1'b0;
        look();
        chk("rst stall1", {31'd0, stall1}, 32'd0);
        chk("rst req2", {31'd0, bus2.mem_req_o}, 32'd0);
        chk("rst wmask4", {28'd0, bus4.mem_wmask_o}, 32'd0);
        chk("rst err4", {31'd0, err4}, 32'd0);
        chk("nonmem rd_data", rdd1, 32'h1357_9BDF);
        chk("nonmem rd_addr", {27'd0, rda1}, 32'd7);
        $display("txn reset done");
        cyc();

        // SW on 1-lane bus, grant always high
        sel = 2'd0; se = 1'b1; f3 = 3'b010; addr = 32'h100; sd = 32'hA1B2_C3D4;
        bus1.mem_gnt_i = 1'b1;
        look();
        chk("sw idle stall", {31'd0, stall1}, 32'd1);
        chk("sw idle req", {31'd0, bus1.mem_req_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); look();
            chk($sformatf("sw b%0d req", k), {31'd0, bus1.mem_req_o}, 32'd1);
            chk($sformatf("sw b%0d addr", k), bus1.mem_addr_o, 32'h100 + 32'(k));
            chk($sformatf("sw b%0d wdata", k), {24'd0, bus1.mem_wdata_o}, {24'd0, sw_bytes[k]});
            chk($sformatf("sw b%0d mask", k), {31'd0, bus1.mem_wmask_o}, 32'd1);
            chk($sformatf("sw b%0d wr", k), {31'd0, bus1.mem_wr_o}, 32'd1);
            chk($sformatf("sw b%0d stall", k), {31'd0, stall1}, 32'd1);
        end
        cyc(); look();
        chk("sw done stall", {31'd0, stall1}, 32'd0);
        chk("sw done req", {31'd0, bus1.mem_req_o}, 32'd0);
        chk("sw done rd_data", rdd1, 32'h1357_9BDF);
        chk("sw done rd_we", {31'd0, rdwe1}, 32'd1);
        cyc();
        se = 1'b0; bus1.mem_gnt_i = 1'b0;
        look();
        chk("sw after stall", {31'd0, stall1}, 32'd0);
        $display("txn SW addr=100 data=a1b2c3d4 bus=1");

        // LB then LBU on 4-lane bus
        sel = 2'd2; le = 1'b1; f3 = 3'b000; addr = 32'h203; bus4.mem_gnt_i = 1'b1;
        look();
        chk("lb idle stall", {31'd0, stall4}, 32'd1);
        cyc(); look();
        chk("lb req", {31'd0, bus4.mem_req_o}, 32'd1);
        chk("lb addr", bus4.mem_addr_o, 32'h203);
        chk("lb mask", {28'd0, bus4.mem_wmask_o}, 32'h1);
        chk("lb wr", {31'd0, bus4.mem_wr_o}, 32'd0);
        cyc();
        bus4.mem_gnt_i = 1'b0; bus4.mem_rvalid_i = 1'b1; bus4.mem_rdata_i = 32'hAABB_CC80;
        look();
        chk("lb wait req", {31'd0, bus4.mem_req_o}, 32'd0);
        chk("lb wait stall", {31'd0, stall4}, 32'd1);
        cyc();
        bus4.mem_rvalid_i = 1'b0;
        look();
        chk("lb result", rdd4, 32'hFFFF_FF80);
        chk("lb done stall", {31'd0, stall4}, 32'd0);
        $display("txn LB addr=203 result=%h", rdd4);
        cyc();
        f3 = 3'b100; bus4.mem_gnt_i = 1'b1;
        look();
        chk("lbu idle stall", {31'd0, stall4}, 32'd1);
        cyc(); look();
        chk("lbu mask", {28'd0, bus4.mem_wmask_o}, 32'h1);
        cyc();
        bus4.mem_gnt_i = 1'b0; bus4.mem_rvalid_i = 1'b1;
        cyc();
        bus4.mem_rvalid_i = 1'b0;
        look();
        chk("lbu result", rdd4, 32'h0000_0080);
        $display("txn LBU addr=203 result=%h", rdd4);
        cyc();
        le = 1'b0;

        // LW on 2-lane bus, unaligned, read data delayed
        sel = 2'd1; le = 1'b1; f3 = 3'b010; addr = 32'h11;
        look();
        chk("lw idle stall", {31'd0, stall2}, 32'd1);
        cyc();
        bus2.mem_gnt_i = 1'b1; bus2.mem_rvalid_i = 1'b1; bus2.mem_rdata_i = 16'hDEAD;
        look();
        chk("lw b0 req", {31'd0, bus2.mem_req_o}, 32'd1);
        chk("lw b0 addr", bus2.mem_addr_o, 32'h11);
        chk("lw b0 mask", {30'd0, bus2.mem_wmask_o}, 32'h3);
        cyc();
        bus2.mem_gnt_i = 1'b0; bus2.mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk($sformatf("lw b0 wait%0d stall", i), {31'd0, stall2}, 32'd1);
            chk($sformatf("lw b0 wait%0d req", i), {31'd0, bus2.mem_req_o}, 32'd0);
            cyc();
        end
        bus2.mem_rvalid_i = 1'b1; bus2.mem_rdata_i = 16'h5678;
        cyc();
        bus2.mem_rvalid_i = 1'b0; bus2.mem_gnt_i = 1'b1;
        look();
        chk("lw b1 req", {31'd0, bus2.mem_req_o}, 32'd1);
        chk("lw b1 addr", bus2.mem_addr_o, 32'h13);
        cyc();
        bus2.mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk($sformatf("lw b1 wait%0d stall", i), {31'd0, stall2}, 32'd1);
            cyc();
        end
        bus2.mem_rvalid_i = 1'b1; bus2.mem_rdata_i = 16'h1234;
        cyc();
        bus2.mem_rvalid_i = 1'b0;
        look();
        chk("lw result", rdd2, 32'h1234_5678);
        chk("lw done stall", {31'd0, stall2}, 32'd0);
        $display("txn LW addr=11 result=%h", rdd2);
        cyc();
        le = 1'b0;

        // Misaligned SH and illegal load funct3 on the aligned-checking instance
        sel = 2'd2; se = 1'b1; f3 = 3'b001; addr = 32'h301; rdwe = 1'b1;
        look();
        chk("sh err", {31'd0, err4}, 32'd1);
        chk("sh req", {31'd0, bus4.mem_req_o}, 32'd0);
        chk("sh rd_we", {31'd0, rdwe4}, 32'd0);
        chk("sh stall", {31'd0, stall4}, 32'd0);
        cyc(); look();
        chk("sh no beat", {31'd0, bus4.mem_req_o}, 32'd0);
        se = 1'b0; le = 1'b1; f3 = 3'b011; addr = 32'h300;
        look();
        chk("ld011 err", {31'd0, err4}, 32'd1);
        chk("ld011 stall", {31'd0, stall4}, 32'd0);
        $display("txn SH addr=301 err=%0d / LD funct3=011", err4);
        cyc();
        le = 1'b0;
        look();
        chk("err clear", {31'd0, err4}, 32'd0);
        chk("rd_we restore", {31'd0, rdwe4}, 32'd1);

        // SB with grant withheld for 5 cycles
        sel = 2'd0; se = 1'b1; f3 = 3'b000; addr = 32'h40; sd = 32'h1234_565A;
        bus1.mem_gnt_i = 1'b0;
        look();
        chk("sb idle stall", {31'd0, stall1}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(); look();
            chk($sformatf("sb hold%0d req", i), {31'd0, bus1.mem_req_o}, 32'd1);
            chk($sformatf("sb hold%0d addr", i), bus1.mem_addr_o, 32'h40);
            chk($sformatf("sb hold%0d data", i), {24'd0, bus1.mem_wdata_o}, 32'h5A);
            chk($sformatf("sb hold%0d mask", i), {31'd0, bus1.mem_wmask_o}, 32'd1);
        end
        cyc();
        bus1.mem_gnt_i = 1'b1;
        look();
        chk("sb gnt req", {31'd0, bus1.mem_req_o}, 32'd1);
        cyc();
        bus1.mem_gnt_i = 1'b0;
        look();
        chk("sb done stall", {31'd0, stall1}, 32'd0);
        chk("sb done req", {31'd0, bus1.mem_req_o}, 32'd0);
        $display("txn SB addr=40 data=5a gnt delayed 5");
        cyc();
        se = 1'b0;

        // Reset in the second read wait of an LW, then a clean LH
        sel = 2'd1; le = 1'b1; f3 = 3'b010; addr = 32'h20;
        look();
        chk("rlw idle stall", {31'd0, stall2}, 32'd1);
        cyc();
        bus2.mem_gnt_i = 1'b1;
        look();
        chk("rlw b0 addr", bus2.mem_addr_o, 32'h20);
        cyc();
        bus2.mem_gnt_i = 1'b0; bus2.mem_rvalid_i = 1'b1; bus2.mem_rdata_i = 16'hBBAA;
        cyc();
        bus2.mem_rvalid_i = 1'b0; bus2.mem_gnt_i = 1'b1;
        look();
        chk("rlw b1 addr", bus2.mem_addr_o, 32'h22);
        cyc();
        bus2.mem_gnt_i = 1'b0; rst = 1'b1;
        look();
        chk("rlw in-rst stall", {31'd0, stall2}, 32'd0);
        cyc();
        rst = 1'b0; le = 1'b0; bus2.mem_rvalid_i = 1'b1; bus2.mem_rdata_i = 16'h7777;
        look();
        chk("rlw post-rst stall", {31'd0, stall2}, 32'd0);
        chk("rlw post-rst req", {31'd0, bus2.mem_req_o}, 32'd0);
        chk("rlw post-rst rd_data", rdd2, 32'h1357_9BDF);
        cyc();
        bus2.mem_rvalid_i = 1'b0; le = 1'b1; f3 = 3'b001; addr = 32'h30;
        look();
        chk("lh idle stall", {31'd0, stall2}, 32'd1);
        cyc();
        bus2.mem_gnt_i = 1'b1;
        look();
        chk("lh addr", bus2.mem_addr_o, 32'h30);
        chk("lh mask", {30'd0, bus2.mem_wmask_o}, 32'h3);
        cyc();
        bus2.mem_gnt_i = 1'b0; bus2.mem_rvalid_i = 1'b1; bus2.mem_rdata_i = 16'h8001;
        cyc();
        bus2.mem_rvalid_i = 1'b0;
        look();
        chk("lh result", rdd2, 32'hFFFF_8001);
        chk("lh done stall", {31'd0, stall2}, 32'd0);
        $display("txn LH after reset result=%h", rdd2);
        cyc();
        le = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Next-generation MEM-stage load/store engine between EX/MEM latch and memory controller.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW as a clocked FSM, splitting each access into beats of BUS_BYTES byte lanes with a req/gnt/rvalid handshake.
- Holds the pipeline via stall_req_o until the access completes.
- Passes non-memory results straight to WB/forwarding; optionally flags misaligned accesses instead of performing them.

Parameters:
- BUS_BYTES, 1, byte lanes per memory beat; legal values 1, 2, 4.
- CHECK_ALIGN, 0, 1 = LH/LHU/SH need addr[0]=0 and LW/SW need addr[1:0]=0, else error; 0 = any address allowed.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_enable_i  in  1  current instruction is a load
- store_enable_i  in  1  current instruction is a store (load_enable_i has priority if both are set)
- funct3_i  in  3  RV32I load/store funct3
- addr_i  in  32  effective byte address
- store_data_i  in  32  store data, byte 0 = [7:0]
- rd_data_i  in  32  ALU result for non-memory ops
- rd_addr_i  in  5  destination register
- rd_write_enable_i  in  1  destination write enable
- stall_req_o  out  1  hold upstream pipeline
- mem_req_o  out  1  beat request valid
- mem_wr_o  out  1  1 = write beat, 0 = read beat
- mem_addr_o  out  32  byte address of lane 0 of the beat
- mem_wdata_o  out  8*BUS_BYTES  write lanes, lane j = bits [8j+7:8j]
- mem_wmask_o  out  BUS_BYTES  lane valid mask
- mem_gnt_i  in  1  beat accepted this cycle
- mem_rvalid_i  in  1  read data valid for the oldest granted read beat
- mem_rdata_i  in  8*BUS_BYTES  read lanes
- rd_data_o  out  32  result to WB/forwarding
- rd_addr_o  out  5  = rd_addr_i
- rd_write_enable_o  out  1  rd_write_enable_i masked by err_o
- err_o  out  1  one-cycle pulse: illegal funct3 or misalignment

Behaviour:
- Reset rst is synchronous, active-high.
- While rst is high, or in the cycle after it: state=IDLE, beat counter=0, assembly register=0, mem_req_o=0, stall_req_o=0, err_o=0, mem_wmask_o=0.
- Read data arriving after reset is ignored. Reset mid-access abandons the access; there is no partial WB.
- Access size N is 1, 2 or 4 bytes from funct3[1:0]. Beat count B = ceil(N/BUS_BYTES).
- Beat k uses mem_addr_o = addr_i + k*BUS_BYTES (32-bit wrap). Lane j carries access byte k*BUS_BYTES+j.
- mem_wmask_o[j] = 1 iff k*BUS_BYTES+j < N. This also applies to reads; unmasked lanes are driven 0 and ignored.
- Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010. Any other funct3 is illegal.
- Non-memory cycle (neither enable set): rd_data_o=rd_data_i, stall_req_o=0, err_o=0, FSM stays IDLE.
- IDLE with a legal, aligned memory op: stall_req_o=1 (combinational); latch size, sign flag and direction; go to REQ next cycle.
- IDLE with an illegal or misaligned op: err_o=1, stall_req_o=0, rd_write_enable_o=0, no memory beat, stay IDLE.
- REQ: mem_req_o=1 with beat-k address, data and mask stable until mem_gnt_i.
  - Store on gnt: if k=B-1 go to DONE, else k+1 and stay in REQ.
  - Load on gnt: go to WAIT_R.
- WAIT_R: mem_req_o=0. On mem_rvalid_i, write the masked lanes into assembly bytes k*BUS_BYTES+j. If k=B-1 go to DONE, else k+1 and go to REQ.
- mem_rvalid_i in the same cycle as gnt is not accepted; rvalid is only sampled in WAIT_R.
- DONE: stall_req_o=0. Result on rd_data_o:
  - LB/LH: sign-extend from bit 8N-1.
  - LBU/LHU: zero-extend.
  - LW: full 32 bits.
  - Store: rd_data_i; rd_write_enable_o passes through.
  - Next cycle returns to IDLE. A new op arriving in that IDLE cycle starts immediately.
- stall_req_o=1 in IDLE (with a legal op), REQ and WAIT_R; 0 in DONE.
- Latency with gnt always 1 and rvalid one cycle after gnt: stores take 1+B stall cycles; loads take 1+2B stall cycles; plus the DONE cycle in each case.
- Inputs are held stable by the stall; the FSM uses its latched size and direction, not the live funct3.

Test Plan:
- BUS_BYTES=1, SW addr 0x100, data 0xA1B2C3D4, gnt=1 -> beats 0x100/D4, 0x101/C3, 0x102/B2, 0x103/A1; 4 REQ cycles, DONE at cycle 5, stall low only in DONE.
- BUS_BYTES=4, LB addr 0x203, mem_rdata lane0=0x80 -> one beat, mask 0001, rd_data_o=0xFFFFFF80; same access with LBU -> 0x00000080.
- BUS_BYTES=2, LW addr 0x11, rvalid delayed 3 cycles per beat, rdata 0x5678 then 0x1234 -> addresses 0x11, 0x13; rd_data_o=0x12345678; stall held through all waits.
- CHECK_ALIGN=1, SH addr 0x301 -> err_o pulse, no mem_req_o, rd_write_enable_o=0, stall_req_o=0; load funct3=011 -> err_o.
- mem_gnt_i held 0 for 5 cycles on SB -> mem_req_o, address, data and mask stable all 5 cycles; completes on the first gnt.
- rst asserted in WAIT_R of LW beat 1 -> next cycle IDLE, mem_req_o=0, stall 0; a late rvalid is ignored; a following LH executes correctly.
